// File: rtl/sipo_deser_if.sv
// Bus between the serial-in/parallel-out deserializer and its source/sink.
// parity_err is present only when SIPO_DESER_PARITY_EN is defined.
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             S;
    logic             ser_input;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
`ifdef SIPO_DESER_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        input  S, ser_input, out_ready,
        output out, out_valid, bit_cnt, overrun
`ifdef SIPO_DESER_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        output S, ser_input, out_ready,
        input  out, out_valid, bit_cnt, overrun
`ifdef SIPO_DESER_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a single-entry valid/ready output buffer.
// Define SIPO_DESER_PARITY_EN to append a parity bit to every frame and report parity_err.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
`ifdef SIPO_DESER_PARITY_EN
    , parameter bit ODD_PARITY = 1'b0
`endif
) (
    input  logic         clk,
    input  logic         R_n,
    input  logic         clr,
    sipo_deser_if.master bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SIPO_DESER_PARITY_EN
    typedef enum logic {ST_SHIFT = 1'b0, ST_PAR = 1'b1} state_e;

    // Returns 1 when data plus the received parity bit violate the selected parity.
    function automatic logic parity_err_f(input logic [WIDTH-1:0] data, input logic par);
        return (^data ^ par) ^ ODD_PARITY;
    endfunction
`else
    typedef enum logic {ST_SHIFT = 1'b0} state_e;
`endif

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sh_nxt_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;
    logic             ovr_r;
    logic             ovr_nxt_s;
    logic             perr_r;
    logic             perr_nxt_s;
    logic             load_evt_s;
    logic [WIDTH-1:0] load_word_s;
    logic             load_perr_s;

    // Shift register contents with the current serial bit inserted.
    always_comb begin
        shifted_s = sh_r;
        if (MSB_FIRST) begin
            shifted_s = {sh_r[WIDTH-2:0], bus.ser_input};
        end else begin
            shifted_s = {bus.ser_input, sh_r[WIDTH-1:1]};
        end
    end

    // Frame FSM: bit acceptance, bit counting and the buffer-load event.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sh_nxt_s    = sh_r;
        load_evt_s  = 1'b0;
        load_word_s = sh_r;
        load_perr_s = 1'b0;
        case (state_r)
            ST_SHIFT: begin
                if (bus.S) begin
                    sh_nxt_s = shifted_s;
                    if (cnt_r == CNT_LAST) begin
`ifdef SIPO_DESER_PARITY_EN
                        // Data is complete; the word is loaded only with its parity bit.
                        state_nxt_s = ST_PAR;
                        cnt_nxt_s   = cnt_r + CNT_ONE;
`else
                        cnt_nxt_s   = CNT_ZERO;
                        load_evt_s  = 1'b1;
                        load_word_s = shifted_s;
`endif
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
`ifdef SIPO_DESER_PARITY_EN
            ST_PAR: begin
                if (bus.S) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = CNT_ZERO;
                    load_evt_s  = 1'b1;
                    load_word_s = sh_r;
                    load_perr_s = parity_err_f(sh_r, bus.ser_input);
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_SHIFT;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output buffer: load, consume, or drop the new word and flag overrun.
    always_comb begin
        out_nxt_s   = out_r;
        valid_nxt_s = valid_r;
        ovr_nxt_s   = ovr_r;
        perr_nxt_s  = perr_r;
        if (load_evt_s) begin
            if (!valid_r || bus.out_ready) begin
                out_nxt_s   = load_word_s;
                valid_nxt_s = 1'b1;
                perr_nxt_s  = load_perr_s;
            end else begin
                ovr_nxt_s = 1'b1;
            end
        end else if (valid_r && bus.out_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State registers; clr behaves as a synchronous reset with top priority.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_r <= ST_SHIFT;
            cnt_r   <= CNT_ZERO;
            sh_r    <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            perr_r  <= 1'b0;
        end else if (clr) begin
            state_r <= ST_SHIFT;
            cnt_r   <= CNT_ZERO;
            sh_r    <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sh_r    <= sh_nxt_s;
            out_r   <= out_nxt_s;
            valid_r <= valid_nxt_s;
            ovr_r   <= ovr_nxt_s;
            perr_r  <= perr_nxt_s;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = valid_r;
    assign bus.bit_cnt   = cnt_r;
    assign bus.overrun   = ovr_r;
`ifdef SIPO_DESER_PARITY_EN
    assign bus.parity_err = perr_r;
`else
    // perr_r stays constant without the parity feature.
    logic unused_perr_s;
    assign unused_perr_s = perr_r;
`endif
endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: LSB-first and MSB-first instances share stimulus and are
// compared against a bit-queue reference model, plus table vectors and corner sequences.
module tb_sipo_deser;
    localparam int W  = 8;
`ifdef SIPO_DESER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk = 1'b0;
    logic R_n;
    logic clr;

    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) if_lsb ();
    sipo_deser_if #(.WIDTH(W)) if_msb ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .R_n(R_n), .clr(clr), .bus(if_lsb.master));
    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .R_n(R_n), .clr(clr), .bus(if_msb.master));

    int checks = 0;
    int errors = 0;

    // Reference model: received bits of the current frame and the buffered word,
    // where m_seq[i] holds the i-th bit received.
    logic           q[$];
    logic [W-1:0]   m_seq;
    logic           m_valid;
    logic           m_ovr;
    logic           m_perr;

    typedef struct {
        logic [W-1:0] seq;
        logic [W-1:0] exp_lsb;
        logic [W-1:0] exp_msb;
        logic         exp_perr;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_seq   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic rdy, input logic c);
        logic x;
        if (c) begin
            model_reset();
        end else begin
            if (s) q.push_back(b);
            if (q.size() == FRAME) begin
                if (!m_valid || rdy) begin
                    x = 1'b0;
                    for (int i = 0; i < W; i++) m_seq[i] = q[i];
                    for (int i = 0; i < FRAME; i++) x = x ^ q[i];
                    m_perr  = x;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                q.delete();
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("lsb_out",   32'(if_lsb.out),       32'(m_seq));
        chk("msb_out",   32'(if_msb.out),       32'(rev(m_seq)));
        chk("lsb_valid", 32'(if_lsb.out_valid), 32'(m_valid));
        chk("msb_valid", 32'(if_msb.out_valid), 32'(m_valid));
        chk("lsb_cnt",   32'(if_lsb.bit_cnt),   32'(q.size()));
        chk("msb_cnt",   32'(if_msb.bit_cnt),   32'(q.size()));
        chk("lsb_ovr",   32'(if_lsb.overrun),   32'(m_ovr));
        chk("msb_ovr",   32'(if_msb.overrun),   32'(m_ovr));
`ifdef SIPO_DESER_PARITY_EN
        if (m_valid) begin
            chk("lsb_perr", 32'(if_lsb.parity_err), 32'(m_perr));
            chk("msb_perr", 32'(if_msb.parity_err), 32'(m_perr));
        end
`endif
    endtask

    task automatic step(input logic s, input logic b, input logic rdy, input logic c = 1'b0);
        if_lsb.S = s;  if_lsb.ser_input = b;  if_lsb.out_ready = rdy;
        if_msb.S = s;  if_msb.ser_input = b;  if_msb.out_ready = rdy;
        clr = c;
        @(posedge clk);
        model_step(s, b, rdy, c);
        #1;
        clr = 1'b0;
        check_all();
    endtask

    // Sends one frame; rdy_last applies on the final edge, rdy_rest on the others.
    task automatic send_frame(input logic [W-1:0] seq, input logic par,
                              input logic rdy_last, input logic rdy_rest);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, (i < W) ? seq[i] : par, (i == FRAME - 1) ? rdy_last : rdy_rest);
        end
    endtask

    initial begin
        vecs[0] = '{8'h4D, 8'h4D, 8'hB2, 1'b0};
        vecs[1] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
        vecs[2] = '{8'h01, 8'h01, 8'h80, 1'b1};
        vecs[3] = '{8'hF0, 8'hF0, 8'h0F, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h01, 1'b1};
        vecs[5] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
        vecs[7] = '{8'h07, 8'h07, 8'hE0, 1'b1};

        R_n = 1'b0;
        clr = 1'b0;
        if_lsb.S = 1'b0; if_lsb.ser_input = 1'b0; if_lsb.out_ready = 1'b0;
        if_msb.S = 1'b0; if_msb.ser_input = 1'b0; if_msb.out_ready = 1'b0;
        model_reset();
        #12;
        check_all();
        R_n = 1'b1;

        // Reset asserted mid-word discards the partial word.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_rst_cnt", 32'(if_lsb.bit_cnt), 32'd3);
        R_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_mid_cnt",   32'(if_lsb.bit_cnt),   32'd0);
        chk("rst_mid_valid", 32'(if_lsb.out_valid), 32'd0);
        #1;
        R_n = 1'b1;

        // Table vectors, always ready; first entry is the clean word after reset.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < FRAME - 1; i++) begin
                step(1'b1, (i < W) ? vecs[v].seq[i] : 1'b0, 1'b1);
            end
            chk("tbl_valid_early", 32'(if_lsb.out_valid), 32'd0);
            step(1'b1, (FRAME - 1 < W) ? vecs[v].seq[W-1] : 1'b0, 1'b1);
            chk("tbl_lsb",   32'(if_lsb.out),       32'(vecs[v].exp_lsb));
            chk("tbl_msb",   32'(if_msb.out),       32'(vecs[v].exp_msb));
            chk("tbl_valid", 32'(if_lsb.out_valid), 32'd1);
`ifdef SIPO_DESER_PARITY_EN
            chk("tbl_perr",  32'(if_lsb.parity_err), 32'(vecs[v].exp_perr));
`endif
        end

        // S low for 5 cycles mid-word: count and word hold.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, vecs[0].seq[i], 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("hold_cnt", 32'(if_msb.bit_cnt), 32'd4);
        end
        for (int i = 4; i < W; i++) step(1'b1, vecs[0].seq[i], 1'b1);
`ifdef SIPO_DESER_PARITY_EN
        step(1'b1, 1'b0, 1'b1);
`endif
        chk("hold_msb_word", 32'(if_msb.out), 32'hB2);

        // Backpressure: second word is dropped and overrun sticks until clr.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("bp_ovr_first", 32'(if_lsb.overrun), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("bp_out_kept", 32'(if_lsb.out),     32'hA5);
        chk("bp_ovr",      32'(if_lsb.overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("bp_ovr_sticky", 32'(if_lsb.overrun), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_valid", 32'(if_lsb.out_valid), 32'd0);
        chk("clr_ovr",   32'(if_lsb.overrun),   32'd0);

        // Consume and complete on the same edge.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        chk("sim_out",   32'(if_lsb.out),       32'h3C);
        chk("sim_valid", 32'(if_lsb.out_valid), 32'd1);
        chk("sim_ovr",   32'(if_lsb.overrun),   32'd0);

`ifdef SIPO_DESER_PARITY_EN
        // Parity: load only after the 9th accepted bit.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(1'b1, vecs[0].seq[i], 1'b1);
        chk("par_valid_early", 32'(if_lsb.out_valid), 32'd0);
        chk("par_cnt",         32'(if_lsb.bit_cnt),   32'(W));
        step(1'b1, 1'b0, 1'b1);
        chk("par_ok", 32'(if_lsb.parity_err), 32'd0);
        send_frame(8'h4D, 1'b1, 1'b1, 1'b1);
        chk("par_bad",   32'(if_lsb.parity_err), 32'd1);
        chk("par_valid", 32'(if_lsb.out_valid),  32'd1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
